// File: rtl/screenchar_field_writer_pkg.sv
// Shared definitions for the screen character field writer: ASCII codes,
// the sweep FSM state encoding and a power-of-ten helper.
package screenchar_pkg;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_LATCH = 3'd0,
        ST_DIGIT = 3'd1,
        ST_NEXT  = 3'd2,
        ST_LINE  = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

    // 10^n as a 64-bit constant; n up to 9 keeps it well inside range.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/screenchar_field_writer_div10_step.sv
// One decimal digit extraction step: quotient and remainder of v / 10.
// Purely combinational so it can be swapped for a multiply-shift variant.
module div10_step #(
    parameter int VAL_W = 32
) (
    input  logic [VAL_W-1:0] i_value,
    output logic [VAL_W-1:0] o_quot,
    output logic [3:0]       o_rem
);

    assign o_quot = i_value / VAL_W'(10);
    assign o_rem  = 4'(i_value - (o_quot * VAL_W'(10)));

endmodule

// File: rtl/screenchar_field_writer.sv
// Continuously renders NUM_FIELDS numbers as fixed-width decimal text into
// the screen character RAM, one character per clock, and optionally copies a
// full text line into a fixed RAM region at the end of a sweep.
module screenchar_field_writer
    import screenchar_pkg::*;
#(
    parameter int                NUM_FIELDS = 4,
    parameter int                DIGITS     = 4,
    parameter int                VAL_W      = 32,
    parameter int                ADDR_W     = 8,
    parameter int                LINE_CHARS = 32,
    parameter logic [ADDR_W-1:0] LINE_BASE  = 8'hC0,
    parameter int                LEAD_BLANK = 1
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_FIELDS*VAL_W-1:0]  field_values,
    input  logic [NUM_FIELDS*ADDR_W-1:0] field_base,
    input  logic [LINE_CHARS*8-1:0]      line_content,
    input  logic                         line_ready,
    output logic [7:0]                   wr_data,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         wr_en,
    output logic                         busy,
    output logic                         sweep_done
);

    localparam int IW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int DW = (DIGITS > 1)     ? $clog2(DIGITS)     : 1;
    localparam int KW = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;
    localparam logic [63:0] SAT_LIMIT = pow10(DIGITS);

    fsm_state_t              r_state;
    fsm_state_t              w_state_nxt;
    logic [IW-1:0]           r_idx;
    logic [DW-1:0]           r_d;
    logic [KW-1:0]           r_k;
    logic [VAL_W-1:0]        r_work;
    logic [ADDR_W-1:0]       r_base;
    logic                    r_sat;
    logic                    r_line_pending;
    logic                    r_line_again;
    logic [LINE_CHARS*8-1:0] r_line_snap;
    logic [7:0]              r_wr_data;
    logic [ADDR_W-1:0]       r_wr_addr;
    logic                    r_wr_en;
    logic                    r_sweep_done;

    logic [VAL_W-1:0]        w_cur_val;
    logic [ADDR_W-1:0]       w_cur_base;
    logic                    w_sat;
    logic [VAL_W-1:0]        w_quot;
    logic [3:0]              w_rem;
    logic                    w_last_field;
    logic                    w_last_digit;
    logic                    w_last_char;
    logic [7:0]              w_line_char;
    logic                    w_wr_en;
    logic [7:0]              w_wr_data;
    logic [ADDR_W-1:0]       w_wr_addr;

    assign w_cur_val    = field_values[r_idx*VAL_W +: VAL_W];
    assign w_cur_base   = field_base[r_idx*ADDR_W +: ADDR_W];
    assign w_sat        = (64'(w_cur_val) >= SAT_LIMIT);
    assign w_last_field = (r_idx == IW'(NUM_FIELDS - 1));
    assign w_last_digit = (r_d == DW'(DIGITS - 1));
    assign w_last_char  = (r_k == KW'(LINE_CHARS - 1));
    assign w_line_char  = r_line_snap[r_k*8 +: 8];

    div10_step #(
        .VAL_W (VAL_W)
    ) u_div10 (
        .i_value (r_work),
        .o_quot  (w_quot),
        .o_rem   (w_rem)
    );

    // Next-state selection and the character/address chosen for this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_data   = 8'h00;
        w_wr_addr   = {ADDR_W{1'b0}};
        case (r_state)
            ST_LATCH: begin
                w_state_nxt = ST_DIGIT;
            end
            ST_DIGIT: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_base + ADDR_W'(DIGITS - 1) - ADDR_W'(r_d);
                if (r_sat) begin
                    w_wr_data = CH_NINE;
                end else if ((r_d != {DW{1'b0}}) && (r_work == {VAL_W{1'b0}}) && (LEAD_BLANK != 0)) begin
                    w_wr_data = CH_SPACE;
                end else begin
                    w_wr_data = CH_ZERO + {4'h0, w_rem};
                end
                if (w_last_digit) begin
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_state_nxt = ST_DIGIT;
                end
            end
            ST_NEXT: begin
                if (!w_last_field) begin
                    w_state_nxt = ST_LATCH;
                end else if (r_line_pending) begin
                    w_state_nxt = ST_LINE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_LINE: begin
                w_wr_en   = 1'b1;
                w_wr_addr = LINE_BASE + ADDR_W'(r_k);
                w_wr_data = w_line_char;
                if (w_last_char) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_LINE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_LATCH;
            end
            default: begin
                w_state_nxt = ST_LATCH;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_LATCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Field snapshot, digit counter and running quotient
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_idx  <= {IW{1'b0}};
            r_d    <= {DW{1'b0}};
            r_work <= {VAL_W{1'b0}};
            r_base <= {ADDR_W{1'b0}};
            r_sat  <= 1'b0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    r_work <= w_cur_val;
                    r_base <= w_cur_base;
                    r_sat  <= w_sat;
                    r_d    <= {DW{1'b0}};
                end
                ST_DIGIT: begin
                    r_work <= w_quot;
                    r_d    <= r_d + DW'(1);
                end
                ST_NEXT: begin
                    if (!w_last_field) begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    r_idx <= {IW{1'b0}};
                end
                default: begin
                end
            endcase
        end
    end

    // Line copy: freeze the whole line on entry so the copy is never torn
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_k         <= {KW{1'b0}};
            r_line_snap <= {(LINE_CHARS*8){1'b0}};
        end else begin
            case (r_state)
                ST_NEXT: begin
                    if (w_last_field && r_line_pending) begin
                        r_k         <= {KW{1'b0}};
                        r_line_snap <= line_content;
                    end
                end
                ST_LINE: begin
                    r_k <= r_k + KW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Request tracking; a request seen while a copy runs is kept for the next sweep
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_line_pending <= 1'b0;
            r_line_again   <= 1'b0;
        end else if ((r_state == ST_LINE) && w_last_char) begin
            r_line_pending <= r_line_again | line_ready;
            r_line_again   <= 1'b0;
        end else begin
            r_line_pending <= r_line_pending | line_ready;
            r_line_again   <= r_line_again | (line_ready & (r_state == ST_LINE));
        end
    end

    // Registered RAM write port and sweep-complete pulse
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_en      <= 1'b0;
            r_wr_data    <= 8'h00;
            r_wr_addr    <= {ADDR_W{1'b0}};
            r_sweep_done <= 1'b0;
        end else begin
            r_wr_en      <= w_wr_en;
            r_wr_data    <= w_wr_data;
            r_wr_addr    <= w_wr_addr;
            r_sweep_done <= (r_state == ST_DONE);
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_data    = r_wr_data;
    assign wr_addr    = r_wr_addr;
    assign sweep_done = r_sweep_done;
    assign busy       = r_line_pending | (r_state == ST_LINE);

endmodule

// File: doc/screenchar_field_writer.md
Name: screenchar_field_writer

Overview:
- Generalised successor to the single-purpose velocity/angle character writer.
- Continuously renders NUM_FIELDS unsigned values as DIGITS-wide decimal ASCII strings.
- Writes each string into the dual-port screen character RAM (screenchar_mem) write port, one character per clock.
- On request, also copies a full PS/2 text line into a fixed region; adds reset, leading-zero blanking, overflow saturation and busy/sweep-done status.

Parameters:
- NUM_FIELDS, 4, number of numeric fields rendered per sweep
- DIGITS, 4, decimal characters per field (1..9)
- VAL_W, 32, width of each field value
- ADDR_W, 8, character RAM address width
- LINE_CHARS, 32, characters in the text line
- LINE_BASE, 8'hC0, RAM address of the line's first character
- LEAD_BLANK, 1, 1 = leading zeros rendered as space (8'h20); 0 = rendered as '0'

Ports:
- clock  in  1  system clock; all logic on posedge
- resetn  in  1  synchronous active-low reset
- field_values  in  NUM_FIELDS*VAL_W  field i at [i*VAL_W +: VAL_W]
- field_base  in  NUM_FIELDS*ADDR_W  RAM address of field i's most-significant character
- line_content  in  LINE_CHARS*8  char k at [k*8 +: 8]; k=0 written at LINE_BASE
- line_ready  in  1  single-cycle request to copy line_content
- wr_data  out  8  ASCII character to RAM
- wr_addr  out  ADDR_W  RAM write address
- wr_en  out  1  write strobe, qualifies wr_data/wr_addr
- busy  out  1  high while the line copy is pending or in progress
- sweep_done  out  1  one-cycle pulse after the final write of each sweep

Behaviour:
- Reset (resetn=0 at posedge): state=LATCH, field index=0, line_pending=0, wr_en=0, wr_data=0, wr_addr=0, busy=0, sweep_done=0.
- FSM states: LATCH, DIGIT, NEXT, LINE, DONE.
- LATCH (1 cycle):
  - Snapshot field_values[i] and field_base[i] of the current field into work registers.
  - If value >= 10^DIGITS, set the sat flag.
  - Go to DIGIT with digit counter d=0.
- DIGIT (DIGITS cycles, one write each):
  - Compute q=work/10 and r=work-10*q; write at addr=base+DIGITS-1-d.
  - Character selection:
    - sat=1: '9' (8'h39).
    - d=0: always '0'+r, so a zero value shows '0'.
    - d>0 with work==0 and LEAD_BLANK=1: 8'h20.
    - Otherwise: '0'+r.
  - work<=q. After d=DIGITS-1, go to NEXT.
  - Digits are written LSD first, address descending.
- NEXT:
  - If i<NUM_FIELDS-1: i++, go to LATCH.
  - Else if line_pending: go to LINE with k=0.
  - Else: go to DONE.
- LINE (LINE_CHARS cycles):
  - Write line_content char k at LINE_BASE+k. The whole bus is snapshotted on the cycle LINE is entered.
  - After k=LINE_CHARS-1, clear line_pending and go to DONE.
- DONE: pulse sweep_done=1 for one cycle, i=0, go to LATCH. Sweeping is continuous.
- Outputs wr_* are registered: each write appears one cycle after the FSM selects it. wr_en=0 in LATCH, NEXT and DONE.
- Sweep length:
  - Without line: NUM_FIELDS*(DIGITS+2)+1 cycles.
  - With line: add LINE_CHARS.
- line_ready handling:
  - Sets line_pending on any cycle, including during LINE.
  - A request arriving during LINE is held and serviced in the next sweep: the clear at the end of LINE loses to a simultaneous set.
  - Multiple requests before service collapse to one.
- busy = line_pending OR state==LINE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- Field values may change at any time; only the LATCH snapshot is used, so a field's digits are never torn.
- resetn low mid-sweep or mid-LINE aborts immediately. wr_en is 0 from the next cycle and the pending line request is discarded.

Decomposition:
- Shared package screenchar_pkg holds:
  - ASCII constants CH_ZERO=8'h30, CH_NINE=8'h39, CH_SPACE=8'h20.
  - The FSM state enum.
  - A function pow10(DIGITS) used for the saturation threshold.
- One natural sub-module, div10_step: combinational VAL_W-bit q=v/10, r=v%10. It is reused for each digit and is replaceable by a multiply-shift implementation.

Test Plan:
- NUM_FIELDS=2, DIGITS=4, LEAD_BLANK=1, values {1234, 7}, bases {8'h3C, 8'h5C}:
  - writes 3F='4', 3E='3', 3D='2', 3C='1', then 5F='7', 5E/5D/5C=8'h20.
  - sweep_done every 13 cycles.
- Value 0 with LEAD_BLANK=0 -> "0000". Value 0 with LEAD_BLANK=1 -> "   0".
- Value 10000 (DIGITS=4) -> "9999". Value 9999 -> "9999" with sat=0 and a normal digit path.
- line_ready pulse mid-sweep:
  - busy rises next cycle.
  - After the last field, 32 writes at C0..DF with line_content bytes in order.
  - busy falls when LINE ends; sweep length = 13+32.
- line_ready pulsed during LINE -> line copied again in the following sweep. Two pulses before service -> exactly one copy.
- Assert resetn=0 during the third digit of field 1:
  - next cycle wr_en=0 and all outputs at reset values.
  - after release, writes resume at field 0's LSD address.
